// File: rtl/frame_buffer_read_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_read_arbiter
//
// Shares the single read port of the 320x240 RGB565 capture frame buffer BRAM
// between the VGA display scanner (hard real-time, always wins) and the
// object-detection frame transfer (bursty, stallable). One read is accepted
// per cycle. The granted address is registered onto bram_addr. An owner tag
// travels alongside the read, so the returning data is steered to the
// requester that issued it after a fixed latency of RD_LATENCY+1 cycles.
//
// Optional feature macro: ARB_STATS_EN
//   When defined, the block counts grants per side (disp_gnt_cnt,
//   det_gnt_cnt) and stats_clr clears the counters.
//   When undefined, both counters are tied to 0 and stats_clr is ignored.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   disp_req/addr      display read request (always accepted when asserted)
//   disp_rvalid/rdata  display read return (1-cycle pulse, data held between)
//   det_enable         0 masks det_req
//   det_req/addr       detection read request, held until det_gnt is seen
//   det_gnt            detection accepted this cycle (combinational)
//   det_rvalid/rdata   detection read return (1-cycle pulse, data held between)
//   det_starved        sticky: detection blocked STARVE_LIMIT cycles in a row
//   starve_clr         clears det_starved and the starvation counter
//   bram_addr          registered BRAM read address
//   bram_dout          BRAM read data, valid RD_LATENCY cycles after bram_addr
//   stats_clr          clears the grant statistics
//   disp_gnt_cnt       display grant count (0 without ARB_STATS_EN)
//   det_gnt_cnt        detection grant count (0 without ARB_STATS_EN)
// -----------------------------------------------------------------------------
module frame_buffer_read_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int RD_LATENCY   = 1,    // legal range 1..4
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              det_enable,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  output logic              det_gnt,
  output logic              det_rvalid,
  output logic [DATA_W-1:0] det_rdata,
  output logic              det_starved,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  input  logic              stats_clr,
  output logic [31:0]       disp_gnt_cnt,
  output logic [31:0]       det_gnt_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_DET  = 2'd2
  } owner_t;

  // Stage index RD_LATENCY holds the tag whose data is on bram_dout this cycle.
  localparam int          TAG_DEPTH       = RD_LATENCY + 1;
  localparam logic [15:0] STARVE_CNT_MAX  = 16'hFFFF;
  localparam logic [31:0] STARVE_LIMIT_U  = 32'(STARVE_LIMIT);

  owner_t              tag_r [TAG_DEPTH];
  owner_t              tag_in_s;
  logic [ADDR_W-1:0]   addr_next_s;
  logic                det_gnt_s;
  logic                starve_inc_s;
  logic                starve_set_s;
  logic [15:0]         starve_cnt_r;
  logic [15:0]         starve_cnt_next_s;

  // Fixed-priority arbitration, decided fresh every cycle.
  always_comb begin
    det_gnt_s    = 1'b0;
    tag_in_s     = TAG_NONE;
    addr_next_s  = bram_addr;
    starve_inc_s = 1'b0;
    if (disp_req) begin
      tag_in_s     = TAG_DISP;
      addr_next_s  = disp_addr;
      // Detection wanted the port but lost it to the display.
      starve_inc_s = det_req & det_enable;
    end else if (det_req && det_enable) begin
      det_gnt_s   = 1'b1;
      tag_in_s    = TAG_DET;
      addr_next_s = det_addr;
    end else begin
      // Idle: the address holds, a NONE tag keeps the return path quiet.
      tag_in_s    = TAG_NONE;
      addr_next_s = bram_addr;
    end
  end

  assign det_gnt = det_gnt_s;

  // BRAM read address register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bram_addr <= '0;
    end else begin
      bram_addr <= addr_next_s;
    end
  end

  // Owner-tag shift register aligned with the BRAM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_r[i] <= TAG_NONE;
      end
    end else begin
      tag_r[0] <= tag_in_s;
      for (int i = 1; i < TAG_DEPTH; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Return path: steer bram_dout to the owner; the other side holds its data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      det_rvalid  <= 1'b0;
      det_rdata   <= '0;
    end else begin
      disp_rvalid <= 1'b0;
      det_rvalid  <= 1'b0;
      case (tag_r[RD_LATENCY])
        TAG_DISP: begin
          disp_rvalid <= 1'b1;
          disp_rdata  <= bram_dout;
        end
        TAG_DET: begin
          det_rvalid <= 1'b1;
          det_rdata  <= bram_dout;
        end
        default: begin
          disp_rvalid <= 1'b0;
          det_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter next value and sticky-flag set condition.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    starve_set_s      = 1'b0;
    if (det_gnt_s || starve_clr) begin
      starve_cnt_next_s = 16'd0;
    end else if (starve_inc_s && (starve_cnt_r != STARVE_CNT_MAX)) begin
      starve_cnt_next_s = starve_cnt_r + 16'd1;
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
    // Flag rises on the blocked cycle that brings the count up to the limit.
    if (starve_inc_s && (({16'd0, starve_cnt_r} + 32'd1) >= STARVE_LIMIT_U)) begin
      starve_set_s = 1'b1;
    end else begin
      starve_set_s = 1'b0;
    end
  end

  // Starvation counter and sticky flag; a same-cycle set beats starve_clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= 16'd0;
      det_starved  <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
      if (starve_set_s) begin
        det_starved <= 1'b1;
      end else if (starve_clr) begin
        det_starved <= 1'b0;
      end else begin
        det_starved <= det_starved;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Grant statistics; a clear in the same cycle as a grant leaves zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_gnt_cnt <= 32'd0;
      det_gnt_cnt  <= 32'd0;
    end else if (stats_clr) begin
      disp_gnt_cnt <= 32'd0;
      det_gnt_cnt  <= 32'd0;
    end else begin
      if (disp_req) begin
        disp_gnt_cnt <= disp_gnt_cnt + 32'd1;
      end else begin
        disp_gnt_cnt <= disp_gnt_cnt;
      end
      if (det_gnt_s) begin
        det_gnt_cnt <= det_gnt_cnt + 32'd1;
      end else begin
        det_gnt_cnt <= det_gnt_cnt;
      end
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign disp_gnt_cnt     = 32'd0;
  assign det_gnt_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for frame_buffer_read_arbiter (default parameters).
// The driver pushes an expected return for every read the bench's own
// arbitration rule says is accepted. A monitor pops and compares on every
// rvalid, checking owner, data, latency and that the other side's data held.
// -----------------------------------------------------------------------------
module tb_frame_buffer_read_arbiter;

  localparam int LAT = 2;  // request-to-rvalid edges for RD_LATENCY=1

`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = 17'd0;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        det_enable = 1'b0;
  logic        det_req = 1'b0;
  logic [16:0] det_addr = 17'd0;
  logic        det_gnt;
  logic        det_rvalid;
  logic [15:0] det_rdata;
  logic        det_starved;
  logic        starve_clr = 1'b0;
  logic [16:0] bram_addr;
  logic [15:0] bram_dout = 16'd0;
  logic        stats_clr = 1'b0;
  logic [31:0] disp_gnt_cnt;
  logic [31:0] det_gnt_cnt;

  typedef struct {
    logic        det;
    logic [15:0] data;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_bram_addr = 17'd0;
  logic [31:0] exp_disp_cnt = 32'd0;
  logic [31:0] exp_det_cnt = 32'd0;
  logic [15:0] last_disp = 16'd0;
  logic [15:0] last_det = 16'd0;

  frame_buffer_read_arbiter dut (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .det_enable(det_enable), .det_req(det_req), .det_addr(det_addr),
    .det_gnt(det_gnt), .det_rvalid(det_rvalid), .det_rdata(det_rdata),
    .det_starved(det_starved), .starve_clr(starve_clr),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .stats_clr(stats_clr),
    .disp_gnt_cnt(disp_gnt_cnt), .det_gnt_cnt(det_gnt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bram_fn(input logic [16:0] a);
    return a[15:0] ^ {15'h5A3C, a[16]};
  endfunction

  // One-cycle synchronous-read BRAM model.
  always @(posedge clk) bram_dout <= bram_fn(bram_addr);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  // Monitor: every rvalid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (disp_rvalid || det_rvalid) begin
      if (disp_rvalid && det_rvalid) begin
        tests++; fails++;
        $display("FAIL both_rvalid: got both sides valid expected one (cycle %0d)", cyc);
      end
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got disp=%0b det=%0b expected none (cycle %0d)",
                 disp_rvalid, det_rvalid, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("ret_owner", 32'(det_rvalid), 32'(e.det));
        chk("ret_latency", cyc, e.acc_cyc + LAT);
        if (det_rvalid) begin
          chk("det_rdata", 32'(det_rdata), 32'(e.data));
          chk("disp_rdata_hold", 32'(disp_rdata), 32'(last_disp));
          last_det = e.data;
        end else begin
          chk("disp_rdata", 32'(disp_rdata), 32'(e.data));
          chk("det_rdata_hold", 32'(det_rdata), 32'(last_det));
          last_disp = e.data;
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at a falling edge.
  task automatic drive(input logic dreq, input logic [16:0] daddr, input logic en,
                       input logic treq, input logic [16:0] taddr,
                       input logic sclr, input logic stclr);
    logic exp_gnt;
    exp_t e;
    disp_req = dreq; disp_addr = daddr; det_enable = en; det_req = treq;
    det_addr = taddr; stats_clr = sclr; starve_clr = stclr;
    #1;
    exp_gnt = treq & en & ~dreq;
    chk("det_gnt", 32'(det_gnt), 32'(exp_gnt));
    if (dreq) begin
      e.det = 1'b0; e.data = bram_fn(daddr); e.acc_cyc = cyc + 1;
      sb_q.push_back(e);
      exp_bram_addr = daddr;
      exp_disp_cnt  = exp_disp_cnt + 32'd1;
    end else if (exp_gnt) begin
      e.det = 1'b1; e.data = bram_fn(taddr); e.acc_cyc = cyc + 1;
      sb_q.push_back(e);
      exp_bram_addr = taddr;
      exp_det_cnt   = exp_det_cnt + 32'd1;
    end
    if (sclr) begin
      exp_disp_cnt = 32'd0;
      exp_det_cnt  = 32'd0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("bram_addr", 32'(bram_addr), 32'(exp_bram_addr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    chk({tag, "_disp_rvalid"}, 32'(disp_rvalid), 32'd0);
    chk({tag, "_det_rvalid"}, 32'(det_rvalid), 32'd0);
    chk({tag, "_disp_rdata"}, 32'(disp_rdata), 32'd0);
    chk({tag, "_det_rdata"}, 32'(det_rdata), 32'd0);
    chk({tag, "_det_starved"}, 32'(det_starved), 32'd0);
    chk({tag, "_disp_gnt_cnt"}, disp_gnt_cnt, 32'd0);
    chk({tag, "_det_gnt_cnt"}, det_gnt_cnt, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // Display only, consecutive addresses 0..9.
    for (int i = 0; i < 10; i++) drive(1'b1, 17'(i), 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
    idle(4);

    // Detection only, full frame back-to-back.
    for (int i = 0; i < 76800; i++) drive(1'b0, 17'd0, 1'b1, 1'b1, 17'(i), 1'b0, 1'b0);
    chk("det_burst_last_addr", 32'(bram_addr), 32'd76799);
    idle(4);

    // Both requesting: display for 3 cycles, detection held then granted.
    for (int i = 0; i < 3; i++) drive(1'b1, 17'(100 + i), 1'b1, 1'b1, 17'd500, 1'b0, 1'b0);
    drive(1'b0, 17'd0, 1'b1, 1'b1, 17'd500, 1'b0, 1'b0);
    idle(4);

    // det_enable masks det_req; falling mid-burst leaves in-flight reads intact.
    drive(1'b0, 17'd0, 1'b0, 1'b1, 17'd700, 1'b0, 1'b0);
    drive(1'b0, 17'd0, 1'b1, 1'b1, 17'd701, 1'b0, 1'b0);
    drive(1'b0, 17'd0, 1'b1, 1'b1, 17'd702, 1'b0, 1'b0);
    drive(1'b0, 17'd0, 1'b0, 1'b1, 17'd703, 1'b0, 1'b0);
    idle(4);
    chk("starved_after_mask", 32'(det_starved), 32'd0);

    // Starvation: flag rises exactly on the 1024th blocked cycle.
    for (int i = 0; i < 1023; i++) drive(1'b1, 17'(i), 1'b1, 1'b1, 17'd600, 1'b0, 1'b0);
    chk("starved_before_limit", 32'(det_starved), 32'd0);
    drive(1'b1, 17'd1023, 1'b1, 1'b1, 17'd600, 1'b0, 1'b0);
    chk("starved_at_limit", 32'(det_starved), 32'd1);
    drive(1'b0, 17'd0, 1'b1, 1'b1, 17'd600, 1'b0, 1'b0);
    chk("starved_sticky_after_gnt", 32'(det_starved), 32'd1);
    drive(1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1);
    chk("starved_cleared", 32'(det_starved), 32'd0);

    // Starvation set coinciding with starve_clr: set wins.
    for (int i = 0; i < 1023; i++) drive(1'b1, 17'(2000 + i), 1'b1, 1'b1, 17'd601, 1'b0, 1'b0);
    chk("starved_before_limit2", 32'(det_starved), 32'd0);
    drive(1'b1, 17'd3023, 1'b1, 1'b1, 17'd601, 1'b0, 1'b1);
    chk("starved_set_beats_clr", 32'(det_starved), 32'd1);
    drive(1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1);
    chk("starved_cleared2", 32'(det_starved), 32'd0);
    idle(4);

    // Statistics: 5 display and 7 detection grants, then clear with a grant.
    chk("stats_run_disp", disp_gnt_cnt, sx(exp_disp_cnt));
    chk("stats_run_det", det_gnt_cnt, sx(exp_det_cnt));
    drive(1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
    chk("stats_clr_disp", disp_gnt_cnt, 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 17'(40 + i), 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 17'd0, 1'b1, 1'b1, 17'(50 + i), 1'b0, 1'b0);
    chk("stats_disp_5", disp_gnt_cnt, sx(32'd5));
    chk("stats_det_7", det_gnt_cnt, sx(32'd7));
    drive(1'b1, 17'd60, 1'b0, 1'b0, 17'd0, 1'b1, 1'b0);
    chk("stats_clr_with_gnt_disp", disp_gnt_cnt, 32'd0);
    chk("stats_clr_with_gnt_det", det_gnt_cnt, 32'd0);
    idle(4);

    // Reset with two reads in flight: nothing may return afterwards.
    drive(1'b1, 17'd900, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0);
    drive(1'b0, 17'd0, 1'b1, 1'b1, 17'd901, 1'b0, 1'b0);
    resetn = 1'b0;
    disp_req = 1'b0; det_req = 1'b0; det_enable = 1'b0;
    sb_q.delete();
    last_disp = 16'd0; last_det = 16'd0;
    exp_bram_addr = 17'd0; exp_disp_cnt = 32'd0; exp_det_cnt = 32'd0;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(6);
    chk_reset_vals("after_release");

    // Drain: every accepted read must have returned.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
